stonet_image_feeder: RTL and testbench

- Image source for the spiking-input stage: answers its img_request/input_valid/image handshake.
- Stores images written by the host in a two-slot (ping-pong) buffer.
- Streams exactly WORDS_PER_IMG 32-bit words (4 pixels, MSB byte first) per image, paced by img_request.
- Releases a slot on new_block, so host loading of image N+1 overlaps streaming of image N.

---
 rtl/stonet_pkg.sv | 17 +
 rtl/stonet_img_ram.sv | 30 +++
 rtl/stonet_image_feeder.sv | 137 +++++++++++++
 tb/tb_stonet_image_feeder.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stonet_pkg.sv
// stonet_pkg: shared constants and read-FSM encoding
// for the spiking-input image feeder.
`timescale 1ns/1ps
package stonet_pkg;

  localparam int WORDS_PER_IMG = 196;
  localparam int PIX_PER_WORD  = 4;
  localparam int DATA_W        = 8 * PIX_PER_WORD;
  localparam int CNT_W         = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } rd_state_e;

endpackage

// File: rtl/stonet_img_ram.sv
// stonet_img_ram: simple dual-port image RAM, one write port
// and one registered read port (output cleared on reset).
`timescale 1ns/1ps
module stonet_img_ram #(
  parameter int DEPTH  = 392,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (i_rst)     o_rdata <= '0;
    else if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/stonet_image_feeder.sv
// stonet_image_feeder: ping-pong image buffer that streams one
// image per block to the spiking-input stage.
`timescale 1ns/1ps
module stonet_image_feeder #(
  parameter int WORDS_PER_IMG = stonet_pkg::WORDS_PER_IMG,
  parameter int DATA_W        = stonet_pkg::DATA_W,
  parameter int CNT_W         = stonet_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_wvalid,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_wready,
  input  logic              img_request,
  input  logic              new_block,
  output logic              input_valid,
  output logic [DATA_W-1:0] image,
  output logic              img_avail,
  output logic [15:0]       underrun_cnt,
  output logic [15:0]       images_sent
);

  import stonet_pkg::*;

  localparam int ADDR_W = $clog2(2 * WORDS_PER_IMG);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS_PER_IMG - 1);
  localparam logic [CNT_W-1:0] NWORDS = CNT_W'(WORDS_PER_IMG);
  localparam logic [ADDR_W-1:0] SLOT1 = ADDR_W'(WORDS_PER_IMG);

  rd_state_e r_state, w_next;

  logic [1:0]        r_full;
  logic              r_wslot, r_rslot;
  logic [CNT_W-1:0]  r_wcnt, r_rcnt;
  logic              r_valid;
  logic [15:0]       r_underrun, r_sent;

  logic              w_wr_acc, w_wr_last;
  logic              w_issue, w_release, w_sent, w_under;
  logic [ADDR_W-1:0] w_waddr, w_raddr;

  assign host_wready  = ~r_full[r_wslot];
  assign img_avail    = r_full[0] | r_full[1];
  assign input_valid  = r_valid;
  assign underrun_cnt = r_underrun;
  assign images_sent  = r_sent;

  assign w_wr_acc  = host_wvalid & host_wready;
  assign w_wr_last = w_wr_acc & (r_wcnt == LAST);

  // Slot 1 sits directly after slot 0 so the RAM stays 2*N deep.
  assign w_waddr = r_wslot ? SLOT1 + ADDR_W'(r_wcnt) : ADDR_W'(r_wcnt);
  assign w_raddr = r_rslot ? SLOT1 + ADDR_W'(r_rcnt) : ADDR_W'(r_rcnt);

  always_comb begin
    w_next    = r_state;
    w_issue   = 1'b0;
    w_release = 1'b0;
    w_sent    = 1'b0;
    w_under   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_under = new_block;
        if (r_full[r_rslot]) w_next = ST_STREAM;
      end
      ST_STREAM: begin
        if (new_block) begin
          w_release = 1'b1;
          w_under   = 1'b1;
          w_next    = ST_IDLE;
        end else if (img_request && (r_rcnt < NWORDS)) begin
          w_issue = 1'b1;
          if (r_rcnt == LAST) w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (new_block) begin
          w_release = 1'b1;
          w_sent    = 1'b1;
          w_next    = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_full     <= 2'b00;
      r_wslot    <= 1'b0;
      r_rslot    <= 1'b0;
      r_wcnt     <= '0;
      r_rcnt     <= '0;
      r_valid    <= 1'b0;
      r_underrun <= '0;
      r_sent     <= '0;
    end else begin
      r_state <= w_next;
      r_valid <= w_issue;
      if (w_wr_acc) begin
        r_wcnt <= w_wr_last ? '0 : r_wcnt + CNT_W'(1);
      end
      // Write and release never target the same slot: full gates it.
      if (w_wr_last) begin
        r_full[r_wslot] <= 1'b1;
        r_wslot         <= ~r_wslot;
      end
      if (w_release) begin
        r_full[r_rslot] <= 1'b0;
        r_rslot         <= ~r_rslot;
      end
      if (r_state == ST_IDLE && r_full[r_rslot]) r_rcnt <= '0;
      else if (w_issue) r_rcnt <= r_rcnt + CNT_W'(1);
      if (w_under && r_underrun != 16'hFFFF) begin
        r_underrun <= r_underrun + 16'd1;
      end
      if (w_sent) r_sent <= r_sent + 16'd1;
    end
  end

  stonet_img_ram #(
    .DEPTH  (2 * WORDS_PER_IMG),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_rst   (reset),
    .i_we    (w_wr_acc),
    .i_waddr (w_waddr),
    .i_wdata (host_wdata),
    .i_re    (w_issue),
    .i_raddr (w_raddr),
    .o_rdata (image)
  );

endmodule

// File: tb/tb_stonet_image_feeder.sv
// tb_stonet_image_feeder: scoreboard bench with a table of
// stream patterns plus hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_stonet_image_feeder;

  localparam int WORDS = 196;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        host_wvalid = 1'b0;
  logic [31:0] host_wdata = '0;
  logic        host_wready;
  logic        img_request = 1'b0;
  logic        new_block = 1'b0;
  logic        input_valid;
  logic [31:0] image;
  logic        img_avail;
  logic [15:0] underrun_cnt;
  logic [15:0] images_sent;

  stonet_image_feeder dut (
    .clk          (clk),
    .reset        (reset),
    .host_wvalid  (host_wvalid),
    .host_wdata   (host_wdata),
    .host_wready  (host_wready),
    .img_request  (img_request),
    .new_block    (new_block),
    .input_valid  (input_valid),
    .image        (image),
    .img_avail    (img_avail),
    .underrun_cnt (underrun_cnt),
    .images_sent  (images_sent)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pause_at;
    int pause_len;
    int abort_at;
    int exp_valid;
    int exp_sent;
    int exp_under;
  } vec_t;

  vec_t        vt[6];
  logic [31:0] q[$];
  int          total = 0;
  int          bad = 0;
  int          vcnt = 0;
  int          cyc = 0;
  int          last_wr_cyc = 0;
  logic        c_done = 1'b0;

  function automatic logic [31:0] wd(input logic [7:0] t, input int i);
    return {t, 8'h00, 16'(i)};
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (input_valid) begin
      vcnt++;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL stream_word: got %08h expected none", image);
      end else begin
        logic [31:0] e;
        e = q.pop_front();
        if (image !== e) begin
          bad++;
          $display("FAIL stream_word: got %08h expected %08h", image, e);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic write_img(input logic [7:0] t);
    int i;
    int stall;
    logic acc;
    i = 0;
    stall = 0;
    while (i < WORDS) begin
      host_wvalid = 1'b1;
      host_wdata  = wd(t, i);
      acc = host_wready;
      if (acc) q.push_back(wd(t, i));
      tick();
      if (acc) begin
        i++;
        stall = 0;
        last_wr_cyc = cyc;
      end else if (++stall > 2000) begin
        total++;
        bad++;
        $display("FAIL write_timeout: got word %0d expected %0d", i, WORDS);
        break;
      end
    end
    host_wvalid = 1'b0;
  endtask

  task automatic wait_cnt(input int base, input int target);
    int b;
    b = 0;
    while (vcnt - base < target) begin
      if (++b > 3000) begin
        total++;
        bad++;
        $display("FAIL wait_valid: got %0d expected %0d",
                 vcnt - base, target);
        break;
      end
      tick();
    end
  endtask

  task automatic pulse_nb();
    new_block = 1'b1;
    tick();
    new_block = 1'b0;
  endtask

  task automatic purge(input logic [7:0] t);
    while (q.size() > 0 && q[0][31:24] == t) void'(q.pop_front());
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] b_sent, b_und;
    int base, n, stop;
    logic [7:0] t;

    vt[0] = '{pause_at: -1, pause_len: 0, abort_at: -1,
              exp_valid: 196, exp_sent: 1, exp_under: 0};
    vt[1] = '{pause_at: 50, pause_len: 5, abort_at: -1,
              exp_valid: 196, exp_sent: 1, exp_under: 0};
    vt[2] = '{pause_at: 195, pause_len: 3, abort_at: -1,
              exp_valid: 196, exp_sent: 1, exp_under: 0};
    vt[3] = '{pause_at: -1, pause_len: 0, abort_at: 100,
              exp_valid: 100, exp_sent: 0, exp_under: 1};
    vt[4] = '{pause_at: -1, pause_len: 0, abort_at: 1,
              exp_valid: 1, exp_sent: 0, exp_under: 1};
    vt[5] = '{pause_at: 0, pause_len: 4, abort_at: -1,
              exp_valid: 196, exp_sent: 1, exp_under: 0};

    tick();
    tick();
    reset = 1'b0;
    chk("rst_valid", 32'(input_valid), 0);
    chk("rst_image", image, 0);
    chk("rst_wready", 32'(host_wready), 1);
    chk("rst_avail", 32'(img_avail), 0);
    chk("rst_under", 32'(underrun_cnt), 0);
    chk("rst_sent", 32'(images_sent), 0);

    // Underrun on an empty buffer
    pulse_nb();
    tick();
    chk("under_cnt", 32'(underrun_cnt), 1);
    chk("under_valid", 32'(input_valid), 0);

    // Basic image: latency and back-to-back valid run
    img_request = 1'b1;
    write_img(8'h00);
    n = 0;
    while (!input_valid && n < 20) begin
      tick();
      n++;
    end
    chk("first_latency", 32'(cyc - last_wr_cyc), 2);
    n = 0;
    while (input_valid && n < 300) begin
      n++;
      tick();
    end
    chk("basic_run", 32'(n), WORDS);
    img_request = 1'b0;
    pulse_nb();
    chk("basic_sent", 32'(images_sent), 1);
    chk("basic_avail", 32'(img_avail), 0);

    for (int e = 0; e < 6; e++) begin
      t = 8'h10 + 8'(e);
      img_request = 1'b0;
      write_img(t);
      b_sent = images_sent;
      b_und  = underrun_cnt;
      base   = vcnt;
      if (vt[e].pause_at >= 0) begin
        img_request = 1'b1;
        wait_cnt(base, vt[e].pause_at);
        img_request = 1'b0;
        for (int k = 0; k < vt[e].pause_len; k++) begin
          tick();
          chk("pause_valid", 32'(input_valid), 0);
          if (vt[e].pause_at > 0)
            chk("pause_hold", image, wd(t, vt[e].pause_at - 1));
        end
      end
      img_request = 1'b1;
      stop = (vt[e].abort_at >= 0) ? vt[e].abort_at : WORDS;
      wait_cnt(base, stop);
      if (vt[e].abort_at >= 0) begin
        pulse_nb();
        img_request = 1'b0;
        chk("abort_valid", 32'(input_valid), 0);
        purge(t);
      end else begin
        img_request = 1'b0;
        tick();
        pulse_nb();
      end
      tick();
      chk("vec_valid", 32'(vcnt - base), 32'(vt[e].exp_valid));
      chk("vec_sent", 32'(16'(images_sent - b_sent)), 32'(vt[e].exp_sent));
      chk("vec_under", 32'(16'(underrun_cnt - b_und)),
          32'(vt[e].exp_under));
      chk("vec_avail", 32'(img_avail), 0);
    end

    // Ping-pong backpressure: A,B buffered, C waits for a free slot
    img_request = 1'b0;
    b_sent = images_sent;
    write_img(8'h2A);
    write_img(8'h2B);
    chk("pp_wready_full", 32'(host_wready), 0);
    chk("pp_avail", 32'(img_avail), 1);
    base = vcnt;
    fork
      begin
        write_img(8'h2C);
        c_done = 1'b1;
      end
      begin
        img_request = 1'b1;
        wait_cnt(base, WORDS);
        img_request = 1'b0;
        pulse_nb();
        chk("pp_wready_free", 32'(host_wready), 1);
        img_request = 1'b1;
        wait_cnt(base, 2 * WORDS);
        img_request = 1'b0;
        pulse_nb();
        n = 0;
        while (!c_done && n < 3000) begin
          tick();
          n++;
        end
        img_request = 1'b1;
        wait_cnt(base, 3 * WORDS);
        img_request = 1'b0;
        pulse_nb();
      end
    join
    tick();
    chk("pp_count", 32'(vcnt - base), 3 * WORDS);
    chk("pp_sent", 32'(16'(images_sent - b_sent)), 3);

    // Reset mid-stream while the other slot fills
    write_img(8'h40);
    base = vcnt;
    img_request = 1'b1;
    n = 0;
    while (vcnt - base < 80 && n < 1000) begin
      host_wvalid = 1'b1;
      host_wdata  = wd(8'h41, n);
      n++;
      tick();
    end
    host_wvalid = 1'b0;
    img_request = 1'b0;
    reset = 1'b1;
    q.delete();
    tick();
    chk("mid_rst_valid", 32'(input_valid), 0);
    chk("mid_rst_image", image, 0);
    chk("mid_rst_wready", 32'(host_wready), 1);
    chk("mid_rst_avail", 32'(img_avail), 0);
    chk("mid_rst_under", 32'(underrun_cnt), 0);
    chk("mid_rst_sent", 32'(images_sent), 0);
    reset = 1'b0;
    tick();
    write_img(8'h42);
    base = vcnt;
    img_request = 1'b1;
    wait_cnt(base, WORDS);
    img_request = 1'b0;
    tick();
    pulse_nb();
    tick();
    chk("fresh_count", 32'(vcnt - base), WORDS);
    chk("fresh_sent", 32'(images_sent), 1);
    chk("fresh_q_empty", 32'(q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
